// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch prefetch queue with redirect/drain handling
//
// Purpose : issues sequential word fetches to instruction memory, tags each
//           request with its PC, buffers in-order responses in a DEPTH-entry
//           queue and presents the head to decode. Redirects flush the queue
//           and discard responses that are still in flight.
// Ports   : clk, rst (async active-low)
//           imem_req_o/imem_addr_o/imem_gnt_i   fetch request handshake
//           imem_rvalid_i/imem_rdata_i          in-order fetch responses
//           redirect_i/redirect_pc_i            branch/jump redirect
//           stall_i                             decode back-pressure
//           id_valid_o/id_pc_o/id_inst_o        queue head to decode
// Config  : IF_PREFETCH_BYPASS_EN - when defined, a live response arriving
//           while the queue is empty is presented to decode in the same cycle.

module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_live;
    logic [CW-1:0] r_discard;

    // tag FIFO: PC of every live outstanding request, in request order
    logic [31:0]   r_t_pc [DEPTH];
    logic [AW-1:0] r_t_rd;
    logic [AW-1:0] r_t_wr;

    // prefetch queue
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_inst [DEPTH];
    logic [AW-1:0] r_q_rd;
    logic [AW-1:0] r_q_wr;
    logic [CW-1:0] r_q_cnt;

    logic          w_fire;
    logic          w_rsp_drop;
    logic          w_rsp_live;
    logic          w_q_empty;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redir_pc;
    logic [CW-1:0] w_live_nxt;
    logic [CW-1:0] w_disc_nxt;

    assign w_q_empty  = (r_q_cnt == '0);
    assign w_fire     = imem_req_o && imem_gnt_i;
    assign w_rsp_drop = imem_rvalid_i && (r_discard != '0);
    // a response in the redirect cycle belongs to the old stream and is dropped
    assign w_rsp_live = imem_rvalid_i && (r_discard == '0) && !redirect_i;
    assign w_redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

`ifdef IF_PREFETCH_BYPASS_EN
    assign w_bypass = w_rsp_live && w_q_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign id_valid_o = !w_q_empty || w_bypass;
    assign w_pop      = !w_q_empty && !stall_i;
    assign w_push     = w_rsp_live && !(w_bypass && !stall_i);

    // Queue slots are reserved for every live request, so a push never finds
    // the queue full. Bounding live+discard as well keeps the discard counter
    // within DEPTH when a redirect folds the live requests into it.
    always_comb begin
        imem_req_o = (r_state != S_IDLE)
                  && (({1'b0, r_q_cnt} + {1'b0, r_live}) < DEPTH_W)
                  && (({1'b0, r_live} + {1'b0, r_discard}) < DEPTH_W);
    end
    assign imem_addr_o = r_pc;

    always_comb begin
        w_live_nxt = r_live;
        w_disc_nxt = r_discard;
        if (redirect_i) begin
            // every request still owed a response becomes a discard, including
            // one granted this cycle; a coincident response retires one of them
            w_live_nxt = '0;
            w_disc_nxt = r_discard + r_live + CW'(w_fire) - CW'(imem_rvalid_i);
        end else begin
            w_live_nxt = r_live + CW'(w_fire) - CW'(w_rsp_live);
            w_disc_nxt = r_discard - CW'(w_rsp_drop);
        end
    end

    always_comb begin
        id_pc_o   = '0;
        id_inst_o = '0;
        if (!w_q_empty) begin
            id_pc_o   = r_q_pc[r_q_rd];
            id_inst_o = r_q_inst[r_q_rd];
        end
`ifdef IF_PREFETCH_BYPASS_EN
        else if (w_bypass) begin
            id_pc_o   = r_t_pc[r_t_rd];
            id_inst_o = imem_rdata_i;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_live    <= '0;
            r_discard <= '0;
            r_t_rd    <= '0;
            r_t_wr    <= '0;
            r_q_rd    <= '0;
            r_q_wr    <= '0;
            r_q_cnt   <= '0;
        end else begin
            r_live    <= w_live_nxt;
            r_discard <= w_disc_nxt;

            case (r_state)
                S_IDLE:  r_state <= S_RUN;
                default: r_state <= (w_disc_nxt != '0) ? S_DRAIN : S_RUN;
            endcase

            if (redirect_i) begin
                r_pc    <= w_redir_pc;
                r_t_rd  <= '0;
                r_t_wr  <= '0;
                r_q_rd  <= '0;
                r_q_wr  <= '0;
                r_q_cnt <= '0;
            end else begin
                if (w_fire) begin
                    r_pc   <= r_pc + 32'd4;
                    r_t_wr <= r_t_wr + 1'b1;
                end
                if (w_rsp_live) r_t_rd <= r_t_rd + 1'b1;
                if (w_push)     r_q_wr <= r_q_wr + 1'b1;
                if (w_pop)      r_q_rd <= r_q_rd + 1'b1;
                r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // storage arrays carry no reset; pointers and counts qualify every read
    always_ff @(posedge clk) begin
        if (w_fire && !redirect_i) r_t_pc[r_t_wr] <= r_pc;
        if (w_push && !redirect_i) begin
            r_q_pc[r_q_wr]   <= r_t_pc[r_t_rd];
            r_q_inst[r_q_wr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - randomized self-checking bench for if_prefetch

module tb_if_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_PREFETCH_BYPASS_EN
    localparam int LAT_CYC = 2;
`else
    localparam int LAT_CYC = 3;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // instruction memory contents as a pure function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // memory model: granted addresses awaiting their response, in order
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // stimulus knobs
    int          gnt_pct   = 100;
    int          stall_pct = 0;
    int          redir_pm  = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    bit          force_redir = 0;
    logic [31:0] force_target = '0;
    bit          lat_chk = 0;

    // reference model: expected next fetch address and next decoded PC
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    int          grants = 0;
    int          pops = 0;
    int          since_rst = 0;
    logic [31:0] last_pop_pc, prev_pop_pc;
    bit          prev_req, prev_gnt, prev_redir;
    logic [31:0] prev_addr;

    task automatic cycle();
        bit          redir;
        logic [31:0] tgt;
        @(negedge clk);
        since_rst++;
        imem_gnt_i = ($urandom_range(99) < gnt_pct);
        stall_i    = ($urandom_range(99) < stall_pct);
        redir      = force_redir || ($urandom_range(999) < redir_pm);
        tgt        = force_redir ? force_target : $urandom;
        force_redir   = 0;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (pend_addr.size() > 0 && pend_due[0] <= edge_no + 1) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        #1;
        if (prev_req && !prev_gnt && !prev_redir) begin
            chk("req_hold", imem_req_o, 1'b1);
            chk("addr_hold", imem_addr_o, prev_addr);
        end
        if (prev_redir) chk("valid_after_redirect", id_valid_o, 1'b0);
        if (lat_chk && since_rst == LAT_CYC) begin
            chk("first_valid", id_valid_o, 1'b1);
            chk("first_pc", id_pc_o, RESET_PC);
        end
        if (imem_req_o && imem_gnt_i) begin
            chk("fetch_addr", imem_addr_o, exp_fetch);
            pend_addr.push_back(imem_addr_o);
            pend_due.push_back(edge_no + 1 + $urandom_range(lat_max, lat_min));
            exp_fetch = exp_fetch + 32'd4;
            grants++;
        end
        if (id_valid_o && !stall_i) begin
            chk("id_pc", id_pc_o, exp_pc);
            chk("id_inst", id_inst_o, mem_word(exp_pc));
            prev_pop_pc = last_pop_pc;
            last_pop_pc = id_pc_o;
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redir) begin
            exp_fetch = {tgt[31:2], 2'b00};
            exp_pc    = {tgt[31:2], 2'b00};
        end
        prev_req   = imem_req_o;
        prev_gnt   = imem_gnt_i;
        prev_redir = redir;
        prev_addr  = imem_addr_o;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
        redirect_i = 0; redirect_pc_i = '0; stall_i = 0;
        pend_addr.delete();
        pend_due.delete();
        #1;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_valid", id_valid_o, 1'b0);
        chk("rst_pc", id_pc_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_fetch = RESET_PC;
        exp_pc    = RESET_PC;
        prev_req = 0; prev_gnt = 0; prev_redir = 0;
        since_rst = 0;
    endtask

    task automatic redirect_and_check(input logic [31:0] tgt, input logic [31:0] first_pc,
                                      input logic [31:0] second_pc);
        int  p0;
        bit  ok;
        force_redir  = 1;
        force_target = tgt;
        cycle();
        p0 = pops;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (pops >= p0 + 2) begin
                ok = 1;
                break;
            end
        end
        chk("redir_timeout", ok, 1'b1);
        chk("redir_pc0", (pops == p0 + 2) ? prev_pop_pc : last_pop_pc, first_pc);
        chk("redir_pc1", last_pop_pc, second_pc);
    endtask

    initial begin
        int  g0, p0;
        bit  ok;
        rst = 1'b0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
        redirect_i = 0; redirect_pc_i = '0; stall_i = 0;

        // first fetch latency from reset
        do_reset();
        lat_chk = 1;
        repeat (8) cycle();
        lat_chk = 0;

        // reset with entries sitting in the queue
        stall_pct = 100;
        repeat (6) cycle();
        chk("pre_reset_valid", id_valid_o, 1'b1);
        do_reset();

        // stalled decode: exactly DEPTH fetches, then request drops
        g0 = grants;
        repeat (20) cycle();
        chk("stall_grants", grants - g0, DEPTH);
        chk("stall_req", imem_req_o, 1'b0);
        chk("stall_head", id_pc_o, RESET_PC);
        stall_pct = 0;
        g0 = grants;
        p0 = pops;
        repeat (15) cycle();
        chk("unstall_pops", (pops - p0) >= DEPTH, 1'b1);
        chk("unstall_fetch", grants > g0, 1'b1);

        // redirect with two requests outstanding
        lat_min = 3; lat_max = 3;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (pend_addr.size() == 2) begin
                ok = 1;
                break;
            end
        end
        chk("two_outstanding", ok, 1'b1);
        redirect_and_check(32'h0000_1003, 32'h0000_1000, 32'h0000_1004);

        // address wrap
        lat_min = 1; lat_max = 2;
        redirect_and_check(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);

        // randomized traffic
        gnt_pct = 70; stall_pct = 30; redir_pm = 25; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) cycle();
        chk("random_progress", pops > 500, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
